uart_coord_receiver: RTL

- Receive end of the 8N1 serial link whose transmit side sends packed coordinate bytes {x[3:0], y[3:0]}.
- Deserializes the rx line with an oversampled bit sampler.
- Checks framing, then unpacks each good byte into zero-extended 8-bit x/y targets with a one-cycle valid strobe.
- Raw byte is also output, for LED/debug display in the top-level controller.

---
 rtl/uart_coord_receiver.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/uart_coord_receiver.sv
// Purpose: 8N1 UART receiver; unpacks each good byte {x[3:0], y[3:0]} into 8-bit x/y targets.
// Latency: data/coord valid pulse one clk after the stop-bit decision sample (+1 tick with UART_RX_MAJORITY_EN).
// Backpressure: none; outputs are single-cycle pulses with held data, and the consumer must take them as they occur.
module uart_coord_receiver #(
    parameter int CLK_HZ     = 10000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic       coord_valid,
    output logic       framing_error,
    output logic       busy
);

    localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW      = $clog2(OVERSAMPLE + 2);
`ifdef UART_RX_MAJORITY_EN
    // The vote needs the sample one tick past mid-bit, so every decision slips by one tick.
    localparam int VOTE_LAG = 1;
`else
    localparam int VOTE_LAG = 0;
`endif
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [CW-1:0] START_TGT = CW'(OVERSAMPLE / 2 + VOTE_LAG);
    localparam logic [CW-1:0] BIT_TGT   = CW'(OVERSAMPLE);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          start_edge;
    logic          bit_val;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    // Two-flop synchronizer plus one more stage of history for falling-edge detection; idles high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign start_edge = (state == IDLE) && rx_prev && !rx_sync;
    assign tick       = (tick_cnt == TICK_LAST);
    assign cnt_next   = cnt + 1'b1;

    // Oversample tick divider, realigned to the start edge so sample points sit mid-bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (start_edge || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;

    // Keep the two previous tick samples so the decision tick can vote 2-of-3.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist <= 2'b11;
        end else if (tick) begin
            hist <= {hist[0], rx_sync};
        end
    end

    assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_sync) | (hist[0] & rx_sync);
`else
    assign bit_val = rx_sync;
`endif

    // Frame FSM: start qualification, LSB-first data capture, stop check and line-break hold-off.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            data          <= 8'h00;
            x             <= 8'h02;
            y             <= 8'h02;
            data_valid    <= 1'b0;
            coord_valid   <= 1'b0;
            framing_error <= 1'b0;
            busy          <= 1'b0;
        end else begin
            data_valid    <= 1'b0;
            coord_valid   <= 1'b0;
            framing_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (cnt_next == START_TGT) begin
                            cnt <= '0;
                            if (!bit_val) begin
                                state   <= DATA;
                                bit_idx <= '0;
                            end else begin
                                // Line was high again at mid-start: a glitch, not a frame.
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt_next;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (cnt_next == BIT_TGT) begin
                            cnt            <= '0;
                            shift[bit_idx] <= bit_val;
                            if (bit_idx == 3'd7) begin
                                state <= STOP;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end else begin
                            cnt <= cnt_next;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (cnt_next == BIT_TGT) begin
                            cnt <= '0;
                            if (bit_val) begin
                                // Return to IDLE at stop mid-bit so a zero-gap next start edge is caught.
                                data        <= shift;
                                x           <= {4'h0, shift[7:4]};
                                y           <= {4'h0, shift[3:0]};
                                data_valid  <= 1'b1;
                                coord_valid <= 1'b1;
                                state       <= IDLE;
                                busy        <= 1'b0;
                            end else begin
                                framing_error <= 1'b1;
                                state         <= WAIT_IDLE;
                            end
                        end else begin
                            cnt <= cnt_next;
                        end
                    end
                end
                WAIT_IDLE: begin
                    // A held-low line (break) reports once, then waits for the line to recover.
                    if (rx_sync) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
